// File: rtl/pulse_mon.sv
// -----------------------------------------------------------------------------
// pulse_mon
//
// Watches a free-running pulse train coming from a clock generator and checks
// that its period stays within a programmable tolerance of an expected value.
// The pulse input is synchronised into the OPB_CLK domain, rising edges are
// detected, and the time between consecutive edges is measured in OPB_CLK
// cycles.
//
// Two sticky flags are raised:
//   FAULT - a measured period differed from EXPECT by more than TOL cycles.
//   LOST  - no edge arrived within 2*EXPECT cycles of the previous one.
// A saturating counter records how many fault/lost events have occurred.
//
// Register map (full 32-bit address compare, data zero-extended):
//   0x1 EXPECT[15:0]    RW  expected period in OPB_CLK cycles
//   0x2 TOL[7:0]        RW  allowed deviation in cycles
//   0x3 CTRL            RW  bit0 EN, bit1 CLR (self-clearing, reads 0)
//   0x4 PERIOD[15:0]    RO  last measured period (saturates at 16'hFFFF)
//   0x5 FAULT_CNT[15:0] RO  number of fault/lost events (saturating)
//   0x6 STATUS          RO  bit0 FAULT, bit1 LOST, bits3:2 monitor state
//
// Ports:
//   OPB_CLK      in   1  sole clock, rising edge
//   OPB_RST      in   1  asynchronous active-high reset
//   OPB_ADDR     in  32  register address
//   MON_DI       in  32  write data
//   MON_WE       in   1  write strobe (one write per asserted cycle)
//   MON_RE       in   1  read strobe
//   MON_DO       out 32  read data, combinational, high-Z when not selected
//   PULSE_IN     in   1  monitored pulse, asynchronous to OPB_CLK
//   PULSE_FAULT  out  1  sticky out-of-tolerance flag
//   PULSE_LOST   out  1  sticky missing-pulse flag
// -----------------------------------------------------------------------------
module pulse_mon #(
  parameter logic [15:0] ExpectDflt = 16'd5000,
  parameter logic [7:0]  TolDflt    = 8'd2
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [31:0] OPB_ADDR,
  input  logic [31:0] MON_DI,
  input  logic        MON_WE,
  input  logic        MON_RE,
  output logic [31:0] MON_DO,
  input  logic        PULSE_IN,
  output logic        PULSE_FAULT,
  output logic        PULSE_LOST
);

  localparam logic [31:0] AddrExpect = 32'h0000_0001;
  localparam logic [31:0] AddrTol    = 32'h0000_0002;
  localparam logic [31:0] AddrCtrl   = 32'h0000_0003;
  localparam logic [31:0] AddrPeriod = 32'h0000_0004;
  localparam logic [31:0] AddrFcnt   = 32'h0000_0005;
  localparam logic [31:0] AddrStatus = 32'h0000_0006;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [15:0] expect_reg, expect_next;
  logic [7:0]  tol_reg, tol_next;
  logic        en_reg, en_next;
  logic        clr_reg, clr_next;

  logic        wr_expect, wr_tol, wr_ctrl;

  assign wr_expect = MON_WE && (OPB_ADDR == AddrExpect);
  assign wr_tol    = MON_WE && (OPB_ADDR == AddrTol);
  assign wr_ctrl   = MON_WE && (OPB_ADDR == AddrCtrl);

  // Upper write-data bits have no home in any register.
  logic unused_di;
  assign unused_di = &{1'b0, MON_DI[31:16]};

  always_comb begin
    expect_next = expect_reg;
    tol_next    = tol_reg;
    en_next     = en_reg;
    if (wr_expect) expect_next = MON_DI[15:0];
    if (wr_tol)    tol_next    = MON_DI[7:0];
    if (wr_ctrl)   en_next     = MON_DI[0];
  end

  // CLR is only ever high for the single cycle following its write; the
  // clearing action happens on the edge that ends that cycle.
  assign clr_next = wr_ctrl && MON_DI[1];

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      expect_reg <= ExpectDflt;
      tol_reg    <= TolDflt;
      en_reg     <= 1'b0;
      clr_reg    <= 1'b0;
    end else begin
      expect_reg <= expect_next;
      tol_reg    <= tol_next;
      en_reg     <= en_next;
      clr_reg    <= clr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse synchroniser and rising-edge detect
  // sync_reg[0..1] form the two-flop synchroniser, sync_reg[2] is the delayed
  // copy used for edge detection. edge_reg is registered so the edge event is
  // visible three cycles after the input rises.
  // ---------------------------------------------------------------------------
  logic [2:0] sync_reg;
  logic       edge_reg;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      sync_reg <= 3'b000;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], PULSE_IN};
      edge_reg <= sync_reg[1] & ~sync_reg[2];
    end
  end

  // ---------------------------------------------------------------------------
  // Period measurement FSM
  // ---------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [16:0] cnt_reg, cnt_next;
  logic [15:0] period_reg, period_next;
  logic [15:0] fault_cnt_reg, fault_cnt_next;
  logic        fault_reg, fault_next;
  logic        lost_reg, lost_next;

  logic        run_ok;
  logic        fault_ev, lost_ev, period_load;
  logic [16:0] cnt_inc;
  logic [16:0] expect_ext;
  logic [16:0] timeout;
  logic [16:0] diff;
  logic [15:0] period_sat;

  // The monitor only runs with the values the registers will hold after this
  // edge, so disabling or zeroing EXPECT takes effect on the write itself.
  assign run_ok = en_next && (expect_next != 16'd0);

  // All comparisons are done in 17 bits: 2*EXPECT tops out at 131070 and the
  // counter never exceeds it, so nothing wraps.
  assign cnt_inc    = cnt_reg + 17'd1;
  assign expect_ext = {1'b0, expect_reg};
  assign timeout    = {expect_reg, 1'b0};
  assign diff       = (cnt_reg >= expect_ext) ? (cnt_reg - expect_ext)
                                              : (expect_ext - cnt_reg);
  assign period_sat = cnt_reg[16] ? 16'hFFFF : cnt_reg[15:0];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    fault_ev    = 1'b0;
    lost_ev     = 1'b0;
    period_load = 1'b0;

    if (!run_ok) begin
      state_next = IDLE;
      cnt_next   = 17'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = ARM;
          cnt_next   = 17'd0;
        end

        // First edge after arming only starts the count; there is nothing
        // to compare it against yet.
        ARM: begin
          cnt_next = 17'd0;
          if (edge_reg) begin
            state_next = RUN;
            cnt_next   = 17'd1;
          end
        end

        RUN: begin
          if (wr_expect || wr_tol) begin
            // Limits changed under a measurement: restart so the interval in
            // flight is not judged against stale values.
            state_next = ARM;
            cnt_next   = 17'd0;
          end else if (edge_reg) begin
            period_load = 1'b1;
            fault_ev    = (diff > {9'd0, tol_reg});
            cnt_next    = 17'd1;
          end else if (cnt_inc >= timeout) begin
            lost_ev    = 1'b1;
            state_next = ARM;
            cnt_next   = 17'd0;
          end else begin
            cnt_next = cnt_inc;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = 17'd0;
        end
      endcase
    end
  end

  // Flag/counter update: CLR first, then any event of this cycle on top of
  // it, so an event coinciding with CLR survives (and counts as 1).
  always_comb begin
    fault_next     = fault_reg;
    lost_next      = lost_reg;
    period_next    = period_reg;
    fault_cnt_next = fault_cnt_reg;

    if (clr_reg) begin
      fault_next     = 1'b0;
      lost_next      = 1'b0;
      period_next    = 16'd0;
      fault_cnt_next = 16'd0;
    end

    if (period_load) period_next = period_sat;
    if (fault_ev)    fault_next  = 1'b1;
    if (lost_ev)     lost_next   = 1'b1;

    if ((fault_ev || lost_ev) && (fault_cnt_next != 16'hFFFF)) begin
      fault_cnt_next = fault_cnt_next + 16'd1;
    end
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= 17'd0;
      period_reg    <= 16'd0;
      fault_cnt_reg <= 16'd0;
      fault_reg     <= 1'b0;
      lost_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      period_reg    <= period_next;
      fault_cnt_reg <= fault_cnt_next;
      fault_reg     <= fault_next;
      lost_reg      <= lost_next;
    end
  end

  assign PULSE_FAULT = fault_reg;
  assign PULSE_LOST  = lost_reg;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data;
  logic        rd_hit;

  always_comb begin
    rd_data = 32'd0;
    rd_hit  = 1'b1;
    case (OPB_ADDR)
      AddrExpect: rd_data = {16'd0, expect_reg};
      AddrTol:    rd_data = {24'd0, tol_reg};
      AddrCtrl:   rd_data = {30'd0, 1'b0, en_reg};
      AddrPeriod: rd_data = {16'd0, period_reg};
      AddrFcnt:   rd_data = {16'd0, fault_cnt_reg};
      AddrStatus: rd_data = {28'd0, state_reg, lost_reg, fault_reg};
      default:    rd_hit  = 1'b0;
    endcase
  end

  assign MON_DO = (MON_RE && rd_hit) ? rd_data : 32'bz;

endmodule

// File: doc/pulse_mon.md
PULSE_MON -- requirements
Module: pulse_mon

Interface
REQ-001 Parameter: ExpectDflt, 16'd5000, reset value of EXPECT register (expected pulse period, clock cycles).
REQ-002 Parameter: TolDflt, 8'd2, reset value of TOL register (allowed period deviation, cycles).
REQ-003 Port: OPB_CLK  in  1  sole clock; all state on rising edge.
REQ-004 Port: OPB_RST  in  1  reset, asynchronous, active-high.
REQ-005 Port: OPB_ADDR  in  32  register address; full 32-bit compare.
REQ-006 Port: MON_DI  in  32  write data.
REQ-007 Port: MON_WE  in  1  write strobe, one-cycle write per asserted cycle.
REQ-008 Port: MON_RE  in  1  read strobe.
REQ-009 Port: MON_DO  out  32  read data, combinational; 32'bz unless MON_RE and a mapped address.
REQ-010 Port: PULSE_IN  in  1  monitored pulse/clock from clock generator, asynchronous to OPB_CLK.
REQ-011 Port: PULSE_FAULT  out  1  sticky period-out-of-tolerance flag.
REQ-012 Port: PULSE_LOST  out  1  sticky missing-pulse flag.

Function
REQ-013 Register map, zero-extended to 32 bits: 0x1 EXPECT[15:0] RW; 0x2 TOL[7:0] RW; 0x3 CTRL RW {bit0 EN, bit1 CLR}; 0x4 PERIOD[15:0] RO; 0x5 FAULT_CNT[15:0] RO; 0x6 STATUS RO {bit0 FAULT, bit1 LOST, bits3:2 state}.
REQ-014 CLR SHALL self-clear one cycle after write and always read 0; writes to RO/unmapped addresses SHALL be ignored.
REQ-015 PULSE_IN SHALL pass a 2-flop synchronizer then rising-edge detect; edge event asserts 3 cycles after input rise.
REQ-016 States: IDLE=0, ARM=1, RUN=2; 17-bit counter CNT.
REQ-017 IDLE: CNT=0; go ARM when EN=1 and EXPECT!=0.
REQ-018 ARM: wait for edge, no compare; on edge CNT<=1, go RUN.
REQ-019 RUN, no edge: CNT increments by 1.
REQ-020 RUN, edge: PERIOD<=CNT[15:0] (saturate 16'hFFFF if CNT>65535); if |CNT-EXPECT|>TOL set FAULT and increment FAULT_CNT; CNT<=1; stay RUN.
REQ-021 RUN timeout: when CNT reaches 2*EXPECT (17-bit) with no edge, set LOST, increment FAULT_CNT, go ARM.
REQ-022 Difference and timeout arithmetic SHALL use 17 bits; no wrap.
REQ-023 FAULT_CNT SHALL saturate at 16'hFFFF; a cycle with both fault and timeout conditions counts once.
REQ-024 EN=0 or EXPECT=0 written: go IDLE next cycle from any state; FAULT, LOST, PERIOD, FAULT_CNT held.
REQ-025 Write to EXPECT or TOL while RUN: go ARM (no compare against stale value).
REQ-026 CLR clears FAULT, LOST, PERIOD, FAULT_CNT; a fault/lost event in the same cycle SHALL win (flag set, FAULT_CNT=1).
REQ-027 PULSE_FAULT=FAULT, PULSE_LOST=LOST, registered outputs.

Reset
REQ-028 OPB_RST SHALL asynchronously force: EXPECT=ExpectDflt, TOL=TolDflt, EN=0, CLR=0, state IDLE, CNT=0, PERIOD=0, FAULT_CNT=0, FAULT=0, LOST=0, synchronizer flops=0, PULSE_FAULT=0, PULSE_LOST=0.
REQ-029 Reset asserted mid-measurement SHALL discard partial CNT; after release monitor stays IDLE until EN written.

Verification
REQ-030 Reset, read 0x1/0x2/0x3 -> 5000, 2, 0; MON_DO=Z with MON_RE=0.
REQ-031 EN=1, PULSE_IN period 5001 cycles for 10 pulses -> PERIOD=5001, FAULT=0, FAULT_CNT=0.
REQ-032 One interval of 5010 cycles -> PERIOD=5010, PULSE_FAULT=1, FAULT_CNT=1; stays 1 after subsequent 5000-cycle periods.
REQ-033 Stop PULSE_IN in RUN -> PULSE_LOST=1 exactly 10000 cycles after last edge event, state=ARM, FAULT_CNT incremented.
REQ-034 CLR written in same cycle as out-of-tolerance edge -> FAULT=1, FAULT_CNT=1; CLR alone -> all flags/counters 0.
REQ-035 EXPECT=3, TOL=0, pulses every 3 cycles, then EN=0 mid-RUN -> no fault, state IDLE next cycle, PERIOD=3 held.
